dt_engine_param: RTL and testbench

Parametrised two-pass distance-transform engine. It streams a packed binary image from a read-only pixel memory (sti) into a result RAM (res) as 0/1 bytes. It then runs a forward raster pass and a backward raster pass in place, leaving each object pixel's distance to the nearest background pixel. It generalises the fixed 128x128 chessboard engine with configurable image size, word width and distance width, a run-time metric select, start/busy handshake, saturation and explicit border handling.

---
 rtl/dt_engine_param.sv | 242 ++++++++++++++++++++++++
 tb/tb_dt_engine_param.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dt_engine_param.sv
// Two-pass distance-transform engine: unpacks a binary image from sti into res,
// then runs a forward and a backward raster pass in place (chessboard or city-block).
module dt_engine_param #(
    parameter  int IMG_W_LOG2 = 7,
    parameter  int IMG_H_LOG2 = 7,
    parameter  int WORD_W     = 16,
    parameter  int DIST_W     = 8,
    localparam int RA_W       = IMG_W_LOG2 + IMG_H_LOG2,
    localparam int SA_W       = RA_W - $clog2(WORD_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic              sti_rd,
    output logic [SA_W-1:0]   sti_addr,
    input  logic [WORD_W-1:0] sti_di,
    output logic              res_rd,
    output logic              res_wr,
    output logic [RA_W-1:0]   res_addr,
    output logic [DIST_W-1:0] res_do,
    input  logic [DIST_W-1:0] res_di
);

    localparam int KW = $clog2(WORD_W);

    localparam logic [DIST_W-1:0]     D_MAX    = '1;
    localparam logic [DIST_W:0]       D_ONE    = 1;
    localparam logic [RA_W-1:0]       PIX_LAST = '1;
    localparam logic [RA_W-1:0]       PIX_ONE  = 1;
    localparam logic [IMG_W_LOG2-1:0] X_MAX    = '1;
    localparam logic [IMG_W_LOG2-1:0] X_ONE    = 1;
    localparam logic [IMG_H_LOG2-1:0] Y_MAX    = '1;
    localparam logic [IMG_H_LOG2-1:0] Y_ONE    = 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_RD,
        S_LOAD_WR,
        S_FWD_CUR,
        S_FWD_NB,
        S_FWD_WR,
        S_BWD_CUR,
        S_BWD_NB,
        S_BWD_WR,
        S_FIN
    } state_t;

    state_t              state, state_next;
    logic                mode_q;
    logic [RA_W-1:0]     pix;
    logic [WORD_W-1:0]   word_q;
    logic [1:0]          nb;
    logic [DIST_W-1:0]   cur_q;
    logic [DIST_W-1:0]   min_q;

    logic [IMG_W_LOG2-1:0] x, x_n;
    logic [IMG_H_LOG2-1:0] y, y_n;
    logic                  x_dec, x_inc, y_dec, y_inc;
    logic                  nb_valid;
    logic                  nb_last;
    logic                  word_last;
    logic [DIST_W-1:0]     contrib;
    logic [DIST_W-1:0]     nb_min;
    logic [DIST_W:0]       inc_full;
    logic [DIST_W-1:0]     inc_sat;
    logic [DIST_W-1:0]     bwd_val;

    assign x         = pix[IMG_W_LOG2-1:0];
    assign y         = pix[RA_W-1:IMG_W_LOG2];
    assign word_last = &pix[KW-1:0];
    assign nb_last   = mode_q ? (nb == 2'd1) : (nb == 2'd3);

    // Neighbour slot decode: forward looks at already-finished pixels above/left,
    // backward at pixels below/right, in a fixed slot order per metric.
    always_comb begin
        x_dec = 1'b0;
        x_inc = 1'b0;
        y_dec = 1'b0;
        y_inc = 1'b0;
        case ({state == S_BWD_NB, mode_q, nb})
            4'b0_0_00: begin x_dec = 1'b1; y_dec = 1'b1; end
            4'b0_0_01: y_dec = 1'b1;
            4'b0_0_10: begin x_inc = 1'b1; y_dec = 1'b1; end
            4'b0_0_11: x_dec = 1'b1;
            4'b0_1_00: y_dec = 1'b1;
            4'b0_1_01: x_dec = 1'b1;
            4'b1_0_00: x_inc = 1'b1;
            4'b1_0_01: begin x_dec = 1'b1; y_inc = 1'b1; end
            4'b1_0_10: y_inc = 1'b1;
            4'b1_0_11: begin x_inc = 1'b1; y_inc = 1'b1; end
            4'b1_1_00: x_inc = 1'b1;
            4'b1_1_01: y_inc = 1'b1;
            default: ;
        endcase
    end

    assign x_n = x_dec ? x - X_ONE : (x_inc ? x + X_ONE : x);
    assign y_n = y_dec ? y - Y_ONE : (y_inc ? y + Y_ONE : y);

    // Off-image neighbours count as background, so they are never read and never wrap.
    assign nb_valid = !(x_dec && x == '0) && !(x_inc && x == X_MAX) &&
                      !(y_dec && y == '0) && !(y_inc && y == Y_MAX);

    assign contrib  = nb_valid ? res_di : '0;
    assign nb_min   = (contrib < min_q) ? contrib : min_q;
    assign inc_full = {1'b0, min_q} + D_ONE;
    assign inc_sat  = inc_full[DIST_W] ? D_MAX : inc_full[DIST_W-1:0];
    assign bwd_val  = (inc_sat < cur_q) ? inc_sat : cur_q;

    // NOTE: state and datapath registers use non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    // NOTE: every output and state_next gets a default first so no path through
    // the case can infer a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        sti_rd     = 1'b0;
        sti_addr   = '0;
        res_rd     = 1'b0;
        res_wr     = 1'b0;
        res_addr   = '0;
        res_do     = '0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_LOAD_RD;
            end
            S_LOAD_RD: begin
                busy       = 1'b1;
                sti_rd     = 1'b1;
                sti_addr   = pix[RA_W-1:KW];
                state_next = S_LOAD_WR;
            end
            S_LOAD_WR: begin
                busy     = 1'b1;
                res_wr   = 1'b1;
                res_addr = pix;
                res_do   = {{(DIST_W-1){1'b0}}, word_q[WORD_W-1]};
                if (word_last) state_next = (pix == PIX_LAST) ? S_FWD_CUR : S_LOAD_RD;
            end
            S_FWD_CUR: begin
                busy     = 1'b1;
                res_rd   = 1'b1;
                res_addr = pix;
                if (res_di != '0)          state_next = S_FWD_NB;
                else if (pix == PIX_LAST)  state_next = S_BWD_CUR;
            end
            S_FWD_NB: begin
                busy     = 1'b1;
                res_rd   = nb_valid;
                res_addr = nb_valid ? {y_n, x_n} : '0;
                if (nb_last) state_next = S_FWD_WR;
            end
            S_FWD_WR: begin
                busy       = 1'b1;
                res_wr     = 1'b1;
                res_addr   = pix;
                res_do     = inc_sat;
                state_next = (pix == PIX_LAST) ? S_BWD_CUR : S_FWD_CUR;
            end
            S_BWD_CUR: begin
                busy     = 1'b1;
                res_rd   = 1'b1;
                res_addr = pix;
                if (res_di != '0)    state_next = S_BWD_NB;
                else if (pix == '0)  state_next = S_FIN;
            end
            S_BWD_NB: begin
                busy     = 1'b1;
                res_rd   = nb_valid;
                res_addr = nb_valid ? {y_n, x_n} : '0;
                if (nb_last) state_next = S_BWD_WR;
            end
            S_BWD_WR: begin
                busy       = 1'b1;
                res_wr     = 1'b1;
                res_addr   = pix;
                res_do     = bwd_val;
                state_next = (pix == '0) ? S_FIN : S_BWD_CUR;
            end
            S_FIN: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The pixel index doubles as the load write pointer; its upper bits are the sti word address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q <= 1'b0;
            pix    <= '0;
            word_q <= '0;
            nb     <= '0;
            cur_q  <= '0;
            min_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        pix    <= '0;
                    end
                end
                S_LOAD_RD: word_q <= sti_di;
                S_LOAD_WR: begin
                    word_q <= word_q << 1;
                    pix    <= pix + PIX_ONE;
                end
                S_FWD_CUR, S_BWD_CUR: begin
                    if (res_di != '0) begin
                        cur_q <= res_di;
                        min_q <= D_MAX;
                        nb    <= '0;
                    end else if (state == S_FWD_CUR && pix != PIX_LAST) begin
                        pix <= pix + PIX_ONE;
                    end else if (state == S_BWD_CUR && pix != '0) begin
                        pix <= pix - PIX_ONE;
                    end
                end
                S_FWD_NB, S_BWD_NB: begin
                    min_q <= nb_min;
                    nb    <= nb + 2'd1;
                end
                S_FWD_WR: if (pix != PIX_LAST) pix <= pix + PIX_ONE;
                S_BWD_WR: if (pix != '0)       pix <= pix - PIX_ONE;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dt_engine_param.sv
// Directed bench for dt_engine_param: an 8x8 byte-word instance and a 32x32
// 16-bit-word instance with 3-bit saturating distances, each with sti/res models.
module tb_dt_engine_param;

    localparam int LIMIT = 20000;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 8x8, WORD_W=8, DIST_W=8
    logic       a_start = 1'b0, a_mode = 1'b0;
    logic       a_busy, a_done, a_sti_rd, a_res_rd, a_res_wr;
    logic [2:0] a_sti_addr;
    logic [7:0] a_sti_di;
    logic [5:0] a_res_addr;
    logic [7:0] a_res_do, a_res_di;
    logic [7:0] a_sti [8];
    logic [7:0] a_res [64];

    // 32x32, WORD_W=16, DIST_W=3
    logic        b_start = 1'b0, b_mode = 1'b0;
    logic        b_busy, b_done, b_sti_rd, b_res_rd, b_res_wr;
    logic [5:0]  b_sti_addr;
    logic [15:0] b_sti_di;
    logic [9:0]  b_res_addr;
    logic [2:0]  b_res_do, b_res_di;
    logic [15:0] b_sti [64];
    logic [2:0]  b_res [1024];

    dt_engine_param #(.IMG_W_LOG2(3), .IMG_H_LOG2(3), .WORD_W(8), .DIST_W(8)) u_a (
        .clk(clk), .reset(reset), .start(a_start), .mode(a_mode), .busy(a_busy), .done(a_done),
        .sti_rd(a_sti_rd), .sti_addr(a_sti_addr), .sti_di(a_sti_di),
        .res_rd(a_res_rd), .res_wr(a_res_wr), .res_addr(a_res_addr), .res_do(a_res_do), .res_di(a_res_di)
    );

    dt_engine_param #(.IMG_W_LOG2(5), .IMG_H_LOG2(5), .WORD_W(16), .DIST_W(3)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .mode(b_mode), .busy(b_busy), .done(b_done),
        .sti_rd(b_sti_rd), .sti_addr(b_sti_addr), .sti_di(b_sti_di),
        .res_rd(b_res_rd), .res_wr(b_res_wr), .res_addr(b_res_addr), .res_do(b_res_do), .res_di(b_res_di)
    );

    assign a_sti_di = a_sti[a_sti_addr];
    assign a_res_di = a_res[a_res_addr];
    assign b_sti_di = b_sti[b_sti_addr];
    assign b_res_di = b_res[b_res_addr];

    always @(posedge clk) begin
        if (a_res_wr) a_res[a_res_addr] <= a_res_do;
        if (b_res_wr) b_res[b_res_addr] <= b_res_do;
    end

    // Protocol watch: one strobe at a time, idle write data is zero, nothing moves in reset.
    int a_viol = 0, b_viol = 0, rst_acc = 0;
    always @(negedge clk) begin
        if (int'(a_sti_rd) + int'(a_res_rd) + int'(a_res_wr) > 1 || (!a_res_wr && a_res_do != '0)) a_viol++;
        if (int'(b_sti_rd) + int'(b_res_rd) + int'(b_res_wr) > 1 || (!b_res_wr && b_res_do != '0)) b_viol++;
        if (!reset && (a_sti_rd || a_res_rd || a_res_wr)) rst_acc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // kind 0: lone object at (3,3); 1: all object; 2: all object but (3,3); 3: objects at (0,0),(15,0)
    function automatic int expect_px(int x, int y, int w, int h, int kind, int m, int maxv);
        int b, d, r, ax, ay;
        b = x;
        if (y < b)         b = y;
        if (w - 1 - x < b) b = w - 1 - x;
        if (h - 1 - y < b) b = h - 1 - y;
        b = b + 1;
        ax = (x > 3) ? x - 3 : 3 - x;
        ay = (y > 3) ? y - 3 : 3 - y;
        d  = m ? ax + ay : ((ax > ay) ? ax : ay);
        case (kind)
            0:       r = (x == 3 && y == 3) ? 1 : 0;
            1:       r = b;
            2:       r = (d < b) ? d : b;
            default: r = (y == 0 && (x == 0 || x == 15)) ? 1 : 0;
        endcase
        if (r > maxv) r = maxv;
        return r;
    endfunction

    function automatic int expect_cycles(int words, int word_w, int n_obj, int n_bg, int k);
        return words * (word_w + 1) + 2 * (n_bg + n_obj * (k + 2)) + 1;
    endfunction

    task automatic fill_a(input int kind);
        for (int i = 0; i < 8; i++) a_sti[i] = (kind == 0) ? 8'h00 : 8'hFF;
        if (kind == 0) a_sti[3] = 8'h10;
        if (kind == 2) a_sti[3] = 8'hEF;
        for (int i = 0; i < 64; i++) a_res[i] = 8'hAA;
    endtask

    task automatic fill_b(input int kind);
        for (int i = 0; i < 64; i++) b_sti[i] = (kind == 1) ? 16'hFFFF : 16'h0000;
        if (kind == 3) b_sti[0] = 16'h8001;
        for (int i = 0; i < 1024; i++) b_res[i] = 3'd5;
    endtask

    task automatic check_img_a(input string tag, input int kind, input int m);
        int bad = 0;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                if (a_res[y * 8 + x] !== 8'(expect_px(x, y, 8, 8, kind, m, 255))) bad++;
        check(tag, bad, 0);
    endtask

    task automatic check_img_b(input string tag, input int kind, input int m);
        int bad = 0;
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 32; x++)
                if (b_res[y * 32 + x] !== 3'(expect_px(x, y, 32, 32, kind, m, 7))) bad++;
        check(tag, bad, 0);
    endtask

    task automatic check_idle_outs(input string tag);
        check({tag, "_a"}, {a_busy, a_done, a_sti_rd, a_res_rd, a_res_wr, |a_sti_addr, |a_res_addr, |a_res_do}, 0);
        check({tag, "_b"}, {b_busy, b_done, b_sti_rd, b_res_rd, b_res_wr, |b_sti_addr, |b_res_addr, |b_res_do}, 0);
    endtask

    // Call at a negedge. poke_at >= 0 re-pulses start (with the other mode) mid-run.
    task automatic run_a(input logic m, input int poke_at, output int cyc);
        int guard = 0;
        a_mode  = m;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        cyc = 0;
        while (!a_done && guard < LIMIT) begin
            if (a_busy) cyc++;
            a_start = (guard == poke_at);
            a_mode  = (guard == poke_at) ? ~m : m;
            @(negedge clk);
            guard++;
        end
        a_start = 1'b0;
        a_mode  = m;
        check("a_done_seen", a_done, 1);
        if (a_busy) cyc++;
        @(negedge clk);
        check("a_busy_fall", {a_busy, a_done}, 0);
    endtask

    task automatic run_b(input logic m, output int cyc, output logic [2:0] s0, output logic [2:0] s1,
                         output logic [2:0] s15);
        int   guard = 0;
        logic seen  = 1'b0;
        s0 = 3'd7; s1 = 3'd7; s15 = 3'd7;
        b_mode  = m;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        cyc = 0;
        while (!b_done && guard < LIMIT) begin
            if (b_busy) cyc++;
            if (!seen && b_res_rd) begin
                seen = 1'b1;
                s0 = b_res[0]; s1 = b_res[1]; s15 = b_res[15];
            end
            @(negedge clk);
            guard++;
        end
        check("b_done_seen", b_done, 1);
        if (b_busy) cyc++;
        @(negedge clk);
        check("b_busy_fall", {b_busy, b_done}, 0);
    endtask

    initial begin
        int         cyc, guard;
        logic [2:0] s0, s1, s15;

        #1 reset = 1'b0;
        #1 check_idle_outs("reset_outs");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Lone object pixel, chessboard
        fill_a(0);
        run_a(1'b0, -1, cyc);
        check("s1_cycles", cyc, expect_cycles(8, 8, 1, 63, 4));
        check("s1_px33", a_res[27], 1);
        check_img_a("s1_img", 0, 0);

        // All object, chessboard
        fill_a(1);
        run_a(1'b0, -1, cyc);
        check("ones_cycles", cyc, expect_cycles(8, 8, 64, 0, 4));
        check("ones_px00", a_res[0], 1);
        check("ones_px33", a_res[27], 4);
        check_img_a("ones_img", 1, 0);

        // Background hole at (3,3), both metrics
        fill_a(2);
        run_a(1'b0, -1, cyc);
        check("hole_c_cycles", cyc, expect_cycles(8, 8, 63, 1, 4));
        check("hole_c_px55", a_res[45], 2);
        check("hole_c_px33", a_res[27], 0);
        check_img_a("hole_c_img", 2, 0);

        fill_a(2);
        run_a(1'b1, -1, cyc);
        check("hole_m_cycles", cyc, expect_cycles(8, 8, 63, 1, 2));
        check("hole_m_px55", a_res[45], 3);
        check("hole_m_px33", a_res[27], 0);
        check_img_a("hole_m_img", 2, 1);

        // start (and mode) pulsed while busy must change nothing
        fill_a(0);
        run_a(1'b0, 5, cyc);
        check("poke_cycles", cyc, expect_cycles(8, 8, 1, 63, 4));
        check_img_a("poke_img", 0, 0);

        // Reset during the forward pass aborts at once; a fresh run still works
        fill_a(0);
        a_mode  = 1'b0;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        guard = 0;
        while (!a_res_rd && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("abort_reach_fwd", a_res_rd, 1);
        #2 reset = 1'b0;
        #1 check_idle_outs("abort_outs");
        repeat (3) @(negedge clk);
        check("abort_no_access", rst_acc, 0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_idle", {a_busy, a_done}, 0);
        fill_a(0);
        run_a(1'b0, -1, cyc);
        check("rerun_cycles", cyc, expect_cycles(8, 8, 1, 63, 4));
        check_img_a("rerun_img", 0, 0);

        // 32x32, 3-bit distances: saturation
        fill_b(1);
        run_b(1'b0, cyc, s0, s1, s15);
        check("sat_cycles", cyc, expect_cycles(64, 16, 1024, 0, 4));
        check("sat_px1515", b_res[495], 7);
        check("sat_px11", b_res[33], 2);
        check("sat_px00", b_res[0], 1);
        check_img_b("sat_img", 1, 0);

        // Word MSB is the leftmost pixel
        fill_b(3);
        run_b(1'b0, cyc, s0, s1, s15);
        check("load_px00", s0, 1);
        check("load_px150", s15, 1);
        check("load_px10", s1, 0);
        check("edge_cycles", cyc, expect_cycles(64, 16, 2, 1022, 4));
        check_img_b("edge_img", 3, 0);

        check("a_protocol", a_viol, 0);
        check("b_protocol", b_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
